// File: rtl/game_seq_if.sv
// Bundles the game_seq control inputs and sequencer outputs.
// The master drives the buttons, tick and finish; the slave (game_seq) owns the outputs.
interface game_seq_if;
  logic       tick;
  logic       btn_start;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic       finish;
  logic [1:0] state;
  logic       mode;
  logic [6:0] value;
  logic [1:0] countdown;
  logic [9:0] random_id;

  modport master (
    output tick, btn_start, btn_mode, btn_up, btn_down, finish,
    input  state, mode, value, countdown, random_id
  );

  modport slave (
    input  tick, btn_start, btn_mode, btn_up, btn_down, finish,
    output state, mode, value, countdown, random_id
  );
endinterface

// File: rtl/game_seq.sv
// Typing-game sequencer: mode/value selection, pre-game countdown, game-state
// tracking and a free-running 10-bit LFSR used for word selection.
module game_seq #(
  parameter int TICKS_PER_SEC = 100,
  parameter int COUNTDOWN_SEC = 3
) (
  input  logic       clk,
  input  logic       rst,
  game_seq_if.slave  bus
);

  localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  typedef enum logic [1:0] {
    S_SELECT    = 2'd0,
    S_COUNTDOWN = 2'd1,
    S_INGAME    = 2'd2,
    S_FINISH    = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        mode_q, mode_d;
  logic [6:0]  value_q, value_d;
  logic [1:0]  countdown_q, countdown_d;
  logic [CW-1:0] tick_cnt_q, tick_cnt_d;
  logic [9:0]  lfsr_q, lfsr_d;
  logic [6:0]  value_max;

  assign value_max = mode_q ? 7'd50 : 7'd95;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    value_d     = value_q;
    countdown_d = countdown_q;
    tick_cnt_d  = tick_cnt_q;
    // x^10 + x^7 + 1, new bit enters at the LSB
    lfsr_d      = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};

    unique case (state_q)
      S_SELECT: begin
        if (bus.btn_start) begin
          state_d     = S_COUNTDOWN;
          countdown_d = 2'(COUNTDOWN_SEC);
          tick_cnt_d  = '0;
        end else if (bus.btn_mode) begin
          mode_d  = ~mode_q;
          value_d = mode_q ? 7'd30 : 7'd10;
        end else if (bus.btn_up && !bus.btn_down) begin
          value_d = (value_q >= value_max - 7'd5) ? value_max : value_q + 7'd5;
        end else if (bus.btn_down && !bus.btn_up) begin
          value_d = (value_q <= 7'd10) ? 7'd5 : value_q - 7'd5;
        end
      end
      S_COUNTDOWN: begin
        if (bus.btn_start) begin
          state_d     = S_SELECT;
          countdown_d = 2'd0;
        end else if (bus.tick) begin
          if (tick_cnt_q == CW'(TICKS_PER_SEC - 1)) begin
            tick_cnt_d  = '0;
            countdown_d = countdown_q - 2'd1;
            if (countdown_q == 2'd1) begin
              state_d = S_INGAME;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + CW'(1);
          end
        end
      end
      S_INGAME: begin
        if (bus.btn_start) begin
          state_d = S_SELECT;
        end else if (bus.finish) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        if (bus.btn_start) begin
          state_d = S_SELECT;
        end
      end
      default: state_d = S_SELECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_SELECT;
      mode_q      <= 1'b0;
      value_q     <= 7'd30;
      countdown_q <= 2'd0;
      tick_cnt_q  <= '0;
      lfsr_q      <= 10'h001;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      value_q     <= value_d;
      countdown_q <= countdown_d;
      tick_cnt_q  <= tick_cnt_d;
      lfsr_q      <= lfsr_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.mode      = mode_q;
  assign bus.value     = value_q;
  assign bus.countdown = countdown_q;
  assign bus.random_id = lfsr_q;

endmodule

// File: tb/tb_game_seq.sv
// Scoreboard bench for game_seq: stimulus updates a behavioural model and queues
// the expected outputs; a monitor compares them one cycle later.
module tb_game_seq;
  localparam int TPS = 100;
  localparam int CDS = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  game_seq_if bus ();

  game_seq #(.TICKS_PER_SEC(TPS), .COUNTDOWN_SEC(CDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int st;
    int md;
    int val;
    int cd;
    int rid;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  int   cycle  = 0;

  // Behavioural model: state names as ints, countdown derived from total ticks seen
  int m_state, m_mode, m_value, m_ticks, m_lfsr;

  task automatic model_reset();
    m_state = 0; m_mode = 0; m_value = 30; m_ticks = 0; m_lfsr = 1;
  endtask

  function automatic int m_countdown();
    if (m_state == 1) return CDS - m_ticks / TPS;
    return 0;
  endfunction

  task automatic model_step(input bit st, input bit md, input bit up, input bit dn,
                            input bit tk, input bit fin);
    int vmax;
    m_lfsr = ((m_lfsr << 1) & 10'h3FF) | (((m_lfsr >> 9) ^ (m_lfsr >> 6)) & 1);
    vmax = (m_mode == 1) ? 50 : 95;
    case (m_state)
      0: begin
        if (st) begin m_state = 1; m_ticks = 0; end
        else if (md) begin m_mode = 1 - m_mode; m_value = (m_mode == 1) ? 10 : 30; end
        else if (up && !dn) m_value = (m_value + 5 > vmax) ? vmax : m_value + 5;
        else if (dn && !up) m_value = (m_value - 5 < 5) ? 5 : m_value - 5;
      end
      1: begin
        if (st) m_state = 0;
        else if (tk) begin
          m_ticks++;
          if (m_ticks == CDS * TPS) m_state = 2;
        end
      end
      2: begin
        if (st) m_state = 0;
        else if (fin) m_state = 3;
      end
      default: if (st) m_state = 0;
    endcase
  endtask

  task automatic drive_and_push(input bit st, input bit md, input bit up, input bit dn,
                                input bit tk, input bit fin);
    exp_t e;
    bus.btn_start = st; bus.btn_mode = md; bus.btn_up = up; bus.btn_down = dn;
    bus.tick = tk; bus.finish = fin;
    if (st || md || up || dn)
      $display("txn t=%0t start=%0b mode=%0b up=%0b down=%0b tick=%0b finish=%0b",
               $time, st, md, up, dn, tk, fin);
    model_step(st, md, up, dn, tk, fin);
    e.st = m_state; e.md = m_mode; e.val = m_value; e.cd = m_countdown(); e.rid = m_lfsr;
    exp_q.push_back(e);
  endtask

  task automatic step(input bit st, input bit md, input bit up, input bit dn,
                      input bit tk, input bit fin);
    @(negedge clk);
    drive_and_push(st, md, up, dn, tk, fin);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  // Ticks with an idle cycle between each, so non-tick cycles are exercised
  task automatic ticks(input int n, input bit fin);
    for (int i = 0; i < n; i++) begin
      step(0, 0, 0, 0, 1, fin);
      step(0, 0, 0, 0, 0, fin);
    end
  endtask

  task automatic check_direct(input string name, input int act, input int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic check_reset_values(input string tag);
    check_direct({tag, "_state"}, int'(bus.state), 0);
    check_direct({tag, "_mode"}, int'(bus.mode), 0);
    check_direct({tag, "_value"}, int'(bus.value), 30);
    check_direct({tag, "_countdown"}, int'(bus.countdown), 0);
    check_direct({tag, "_random_id"}, int'(bus.random_id), 1);
  endtask

  // Assert reset between edges, check outputs asynchronously, resume on next edge
  task automatic do_reset(input string tag);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_values(tag);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive_and_push(0, 0, 0, 0, 0, 0);
  endtask

  always begin
    @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cycle++;
      checks++;
      if (int'(bus.state) == e.st && int'(bus.mode) == e.md && int'(bus.value) == e.val &&
          int'(bus.countdown) == e.cd && int'(bus.random_id) == e.rid)
        passed++;
      else
        $display("FAIL snapshot cycle %0d: got st=%0d md=%0d val=%0d cd=%0d rid=%03h, expected st=%0d md=%0d val=%0d cd=%0d rid=%03h",
                 cycle, bus.state, bus.mode, bus.value, bus.countdown, bus.random_id,
                 e.st, e.md, e.val, e.cd, e.rid);
    end
  end

  initial begin
    bus.btn_start = 0; bus.btn_mode = 0; bus.btn_up = 0; bus.btn_down = 0;
    bus.tick = 0; bus.finish = 0;
    model_reset();
    #1 rst = 1'b1;
    #2 check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;
    drive_and_push(0, 0, 0, 0, 0, 0);

    // Value selection and saturation
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 25; i++) step(0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0);

    // Full countdown, finish, acknowledge
    step(1, 0, 1, 0, 1, 0);
    ticks(100, 0);
    ticks(200, 0);
    ticks(3, 0);
    step(0, 1, 1, 0, 0, 1);
    idle(2);
    step(1, 0, 0, 0, 0, 1);

    // Abort from INGAME with finish on the same cycle
    step(1, 0, 0, 0, 0, 0);
    ticks(300, 0);
    step(1, 0, 0, 0, 0, 1);

    // Abort mid-countdown, including abort coinciding with a tick
    step(1, 0, 0, 0, 0, 0);
    ticks(150, 0);
    step(1, 0, 0, 0, 1, 0);
    idle(2);

    // LFSR full period from the reset seed
    do_reset("mid_reset");
    idle(1022);
    @(posedge clk);
    #3;
    check_direct("lfsr_period", int'(bus.random_id), 1);

    // Reset while INGAME
    step(1, 0, 0, 0, 0, 0);
    ticks(300, 0);
    idle(3);
    do_reset("ingame_reset");

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 149) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 1) == 0), ($urandom_range(0, 7) == 0));
    end

    @(negedge clk);
    bus.btn_start = 0; bus.btn_mode = 0; bus.btn_up = 0; bus.btn_down = 0;
    bus.tick = 0; bus.finish = 0;
    @(posedge clk);
    #4;
    check_direct("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
